mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Round-robin scheduler sharing one sequential 8x8 multiplier (ld / mult_rdy / result handshake)
//  between NREQ requesters (colour scaler, intensity scaler, gamma stage, ...).
//  Accepts one operand pair per transaction, sequences the multiplier, and returns the 16-bit product
//  with a done pulse to the granted requester.
//  Sits between the colour datapath and the multiplier instance, on the system clock.
// PARAMETERS
//  NREQ         4    number of requesters (2..8)
//  DW           8    operand width; product width is 2*DW
//  TIMEOUT_CYC  64   WAIT-state watchdog limit in clk cycles (used only with MULT_ARB_TIMEOUT_EN)
// PORTS
//  clk      in   1          system clock, all logic on rising edge
//  reset    in   1          asynchronous, active-high reset
//  req      in   NREQ       request level per requester; hold high, operands stable, until done[i]
//  a_in     in   NREQ*DW    operand A per requester, slice i = a_in[i*DW +: DW]
//  b_in     in   NREQ*DW    operand B per requester, same slicing
//  gnt      out  NREQ       one-hot, 1-cycle pulse: operands of requester i captured
//  done     out  NREQ       one-hot, 1-cycle pulse: res_out valid for requester i
//  err      out  NREQ       one-hot, 1-cycle pulse with done: transaction aborted by timeout
//  res_out  out  2*DW       product of last completed transaction; held until next done
//  busy     out  1          high in every state except IDLE
//  m_ld     out  1          1-cycle load strobe to multiplier
//  m_a      out  DW         operand A to multiplier, registered, stable LOAD..DONE
//  m_b      out  DW         operand B to multiplier, registered, stable LOAD..DONE
//  m_rdy    in   1          multiplier result ready
//  m_res    in   2*DW       multiplier result
// BEHAVIOUR
//  Reset: state IDLE, gnt/done/err=0, res_out=0, m_ld=0, m_a=m_b=0, busy=0, RR pointer=0.
//  FSM: IDLE -> LOAD -> WAIT -> DONE -> IDLE.
//   IDLE: if any req, pick winner i = first set bit at/after pointer (wrapping);
//         capture a_in/b_in slice i into m_a/m_b; go LOAD. No req: stay IDLE.
//   LOAD: m_ld=1 and gnt[i]=1 for exactly this cycle; go WAIT. m_rdy ignored here.
//   WAIT: first cycle m_rdy=1 -> res_out<=m_res, go DONE.
//   DONE: done[i]=1 for 1 cycle; pointer <= (i+1) mod NREQ; go IDLE.
//  Latency: req seen in IDLE at edge t -> gnt/m_ld in cycle t+1 -> done >= t+3+multiplier latency.
//  Back-to-back: requester keeping req high after done is re-eligible; the RR pointer has moved past it,
//   so any other pending requester is served first. Min spacing between transactions: 4 cycles.
//  Withdrawal: req dropping before capture in IDLE is never granted. Dropping req after capture
//   does not abort; the transaction completes and done still pulses.
//  Simultaneous: all requests in the same cycle are served in pointer order, one per transaction.
//  req changes during LOAD/WAIT/DONE are ignored until the next IDLE.
//  reset mid-transaction: immediate return to IDLE with all outputs at reset values;
//   no done pulse for the aborted transaction.
//  Invariants: gnt, done, err each one-hot or zero; at most one transaction outstanding.
// CONFIGURATION
//  MULT_ARB_TIMEOUT_EN defined:
//   WAIT counts cycles; if TIMEOUT_CYC cycles pass without m_rdy -> res_out <= all ones, go DONE,
//   done[i] and err[i] pulse together; the pointer advances normally.
//  MULT_ARB_TIMEOUT_EN undefined:
//   no counter; WAIT waits for m_rdy indefinitely; err tied to 0.
// STRUCTURE
//  Package mult_arb_pkg: FSM state encoding (IDLE=0, LOAD=1, WAIT=2, DONE=3);
//   default NREQ/DW; timeout counter width = clog2(TIMEOUT_CYC+1).
//  Sub-module rr_pick: combinational round-robin picker.
//   Inputs: req vector, pointer. Outputs: one-hot winner, index, any_req.
//  Top level holds FSM, operand and result registers, pointer, and optional watchdog.
// TESTING
//  1. Single req[0], a=8'd200, b=8'd3; model multiplier rdy after 8 cycles.
//     -> gnt[0] 1 cycle after req; m_ld 1 pulse; done[0] with res_out=16'd600.
//  2. req=4'b1111 held, operands i*10+1 and 2.
//     -> done order 0,1,2,3,0,...; each res_out correct; never two one-hot bits set.
//  3. Pointer=2 after serving 1; req=4'b0011.
//     -> requester 0 served before 1 (wrap-around).
//  4. Assert reset while in WAIT.
//     -> next cycle busy=0, m_ld=0, res_out=0, no done.
//     -> a new req afterwards completes normally.
//  5. m_rdy held high from before LOAD (stale).
//     -> ignored in LOAD; result captured in first WAIT cycle; m_a/m_b stable throughout.
//  6. MULT_ARB_TIMEOUT_EN, TIMEOUT_CYC=64, multiplier never ready.
//     -> done[i] & err[i] 64 cycles into WAIT, res_out=16'hFFFF.
//     -> without the macro, busy stays high and err=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the round-robin multiplier-sharing arbiter.
// The optional WAIT watchdog is enabled with MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;

    // Wide enough to hold the watchdog limit itself.
    function automatic int timeoutCntWidth(input int timeoutCyc);
        return $clog2(timeoutCyc + 1);
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_pick import mult_arb_pkg::*; #(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW-1:0] w_cand;

    // Scan from the farthest offset back to the pointer so the nearest request wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_cand]) begin
                o_onehot         = '0;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
                o_any            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier between NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add the WAIT-state watchdog (TIMEOUT_CYC cycles).
module mult_share_arbiter import mult_arb_pkg::*; #(
    parameter int NREQ        = DEF_NREQ,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] a_in,
    input  logic [NREQ*DW-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [2*DW-1:0]   res_out,
    output logic              busy,
    output logic              m_ld,
    output logic [DW-1:0]     m_a,
    output logic [DW-1:0]     m_b,
    input  logic              m_rdy,
    input  logic [2*DW-1:0]   m_res
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_badConfig
        $error("mult_share_arbiter: unsupported NREQ or TIMEOUT_CYC");
    end

    arb_state_t      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [NREQ-1:0] r_sel;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [2*DW-1:0] r_res;
    logic [DW-1:0]   r_ma;
    logic [DW-1:0]   r_mb;
    logic            r_mld;

    logic [NREQ-1:0] w_pickOnehot;
    logic [IW-1:0]   w_pickIdx;
    logic            w_any;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = timeoutCntWidth(TIMEOUT_CYC);
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_err;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pickOnehot),
        .o_idx    (w_pickIdx),
        .o_any    (w_any)
    );

    // Strobes default low each cycle so gnt/m_ld live only in LOAD and done/err only in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_res   <= '0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_mld   <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= '0;
`endif
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            r_mld  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_err  <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_pickOnehot;
                        r_idx   <= w_pickIdx;
                        r_ma    <= a_in[int'(w_pickIdx)*DW +: DW];
                        r_mb    <= b_in[int'(w_pickIdx)*DW +: DW];
                        r_gnt   <= w_pickOnehot;
                        r_mld   <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
`ifdef MULT_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (m_rdy) begin
                        r_res   <= m_res;
                        r_done  <= r_sel;
                        r_state <= DONE;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_res   <= '1;
                        r_done  <= r_sel;
                        r_err   <= r_sel;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign res_out = r_res;
    assign busy    = (r_state != IDLE);
    assign m_ld    = r_mld;
    assign m_a     = r_ma;
    assign m_b     = r_mb;

`ifdef MULT_ARB_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier and round-robin model.
// Timeout expectations follow MULT_ARB_TIMEOUT_EN.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NREQ*DW-1:0] a_in;
    logic [NREQ*DW-1:0] b_in;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic [NREQ-1:0]  err;
    logic [2*DW-1:0]  res_out;
    logic             busy;
    logic             m_ld;
    logic [DW-1:0]    m_a;
    logic [DW-1:0]    m_b;
    logic             m_rdy;
    logic [2*DW-1:0]  m_res;

    logic [DW-1:0] aOp [NREQ];
    logic [DW-1:0] bOp [NREQ];

    int checks   = 0;
    int failures = 0;
    int ptr      = 0;

    int       mulLat    = 4;
    bit       staleMode = 1'b0;
    logic     mRdyQ;
    logic [15:0] mResQ;
    logic [15:0] mProd;
    int       mulCnt;
    logic     mulBusy;

    mult_share_arbiter #(
        .NREQ        (NREQ),
        .DW          (DW),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .res_out (res_out),
        .busy    (busy),
        .m_ld    (m_ld),
        .m_a     (m_a),
        .m_b     (m_b),
        .m_rdy   (m_rdy),
        .m_res   (m_res)
    );

    always #5 clk = ~clk;

    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*DW +: DW] = aOp[i];
            b_in[i*DW +: DW] = bOp[i];
        end
    end

    // Sequential multiplier: ready mulLat cycles after the load strobe, 0 = never ready.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mRdyQ   <= 1'b0;
            mResQ   <= '0;
            mProd   <= '0;
            mulCnt  <= 0;
            mulBusy <= 1'b0;
        end else if (m_ld) begin
            mRdyQ   <= 1'b0;
            mulBusy <= (mulLat != 0);
            mulCnt  <= mulLat;
            mProd   <= 16'(m_a) * 16'(m_b);
        end else if (mulBusy) begin
            if (mulCnt <= 1) begin
                mRdyQ   <= 1'b1;
                mResQ   <= mProd;
                mulBusy <= 1'b0;
            end else begin
                mulCnt <= mulCnt - 1;
            end
        end
    end

    assign m_rdy = staleMode ? 1'b1 : mRdyQ;
    assign m_res = staleMode ? 16'(m_a) * 16'(m_b) : mResQ;

    function automatic int pickModel(input logic [NREQ-1:0] mask, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ptr   = 0;
        tick();
    endtask

    task automatic waitGnt(input string tag, input int idx, output int delay);
        int n = 0;
        while (gnt === '0 && n < 20) begin
            tick();
            n++;
        end
        delay = n;
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(1 << idx));
        checkOutput({tag, ".m_ld"}, 32'(m_ld), 32'd1);
        checkOutput({tag, ".m_a"}, 32'(m_a), 32'(aOp[idx]));
        checkOutput({tag, ".m_b"}, 32'(m_b), 32'(bOp[idx]));
    endtask

    task automatic waitDone(input string tag, input int idx, input bit expErr, output int delay);
        int n = 0;
        logic [15:0] expRes;
        expRes = expErr ? 16'hFFFF : 16'(aOp[idx]) * 16'(bOp[idx]);
        while (done === '0 && n < 300) begin
            tick();
            n++;
        end
        delay = n;
        checkOutput({tag, ".done"}, 32'(done), 32'(1 << idx));
        checkOutput({tag, ".res"}, 32'(res_out), 32'(expRes));
        checkOutput({tag, ".err"}, 32'(err), expErr ? 32'(1 << idx) : 32'd0);
        checkOutput({tag, ".m_aHeld"}, 32'(m_a), 32'(aOp[idx]));
    endtask

    task automatic applyStimulus(input string tag, input logic [NREQ-1:0] mask, input int lat);
        int w;
        int d;
        mulLat = lat;
        req    = mask;
        w      = pickModel(mask, ptr);
        waitGnt(tag, w, d);
        waitDone(tag, w, 1'b0, d);
        ptr = (w + 1) % NREQ;
    endtask

    initial begin
        int d;
        int w;
        logic [NREQ-1:0] seen;
        logic [NREQ-1:0] mask;

        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < NREQ; i++) begin
            aOp[i] = '0;
            bOp[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.gnt", 32'(gnt), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.err", 32'(err), 32'd0);
        checkOutput("rst.res", 32'(res_out), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.m_ld", 32'(m_ld), 32'd0);
        checkOutput("rst.m_a", 32'(m_a), 32'd0);
        checkOutput("rst.m_b", 32'(m_b), 32'd0);
        reset = 1'b0;
        tick();

        // Single requester, fixed operands, 8-cycle multiplier.
        aOp[0] = 8'd200;
        bOp[0] = 8'd3;
        mulLat = 8;
        req    = 4'b0001;
        waitGnt("t1", 0, d);
        checkOutput("t1.gntLat", 32'(d), 32'd1);
        checkOutput("t1.busy", 32'(busy), 32'd1);
        waitDone("t1", 0, 1'b0, d);
        checkOutput("t1.doneLat", 32'(d), 32'd10);
        checkOutput("t1.res600", 32'(res_out), 32'd600);
        req = '0;
        ptr = 1;
        tick();

        // All four requesting continuously: pure rotation.
        resetDut();
        for (int i = 0; i < NREQ; i++) begin
            aOp[i] = 8'(i * 10 + 1);
            bOp[i] = 8'd2;
        end
        for (int t = 0; t < 6; t++) applyStimulus("t2", 4'b1111, 3);
        req = '0;

        // Pointer sits at 2: requester 0 wins over 1 by wrap-around.
        aOp[0] = 8'($urandom);
        bOp[0] = 8'($urandom);
        aOp[1] = 8'($urandom);
        bOp[1] = 8'($urandom);
        applyStimulus("t3a", 4'b0011, 2);
        applyStimulus("t3b", 4'b0011, 2);
        req = '0;
        tick();

        // Reset while the multiplier is still working.
        aOp[2] = 8'($urandom_range(1, 255));
        bOp[2] = 8'($urandom_range(1, 255));
        mulLat = 20;
        req    = 4'b0100;
        w      = pickModel(req, ptr);
        waitGnt("t4", w, d);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("t4.busy", 32'(busy), 32'd0);
        checkOutput("t4.m_ld", 32'(m_ld), 32'd0);
        checkOutput("t4.res", 32'(res_out), 32'd0);
        checkOutput("t4.done", 32'(done), 32'd0);
        checkOutput("t4.m_a", 32'(m_a), 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ptr   = 0;
        seen  = '0;
        repeat (6) begin
            tick();
            seen |= done;
        end
        checkOutput("t4.noDone", 32'(seen), 32'd0);
        aOp[3] = 8'($urandom);
        bOp[3] = 8'($urandom);
        applyStimulus("t4new", 4'b1000, 2);
        req = '0;
        tick();

        // Multiplier ready already high before the load.
        staleMode = 1'b1;
        aOp[1] = 8'($urandom);
        bOp[1] = 8'($urandom);
        req = 4'b0010;
        w   = pickModel(req, ptr);
        waitGnt("t5", w, d);
        waitDone("t5", w, 1'b0, d);
        checkOutput("t5.doneLat", 32'(d), 32'd2);
        ptr = (w + 1) % NREQ;
        staleMode = 1'b0;
        req = '0;
        tick();

        // Requests changing mid-transaction: transient request never granted, drop does not abort.
        aOp[0] = 8'($urandom);
        bOp[0] = 8'($urandom);
        mulLat = 6;
        req    = 4'b0001;
        w      = pickModel(req, ptr);
        waitGnt("t7", w, d);
        req = 4'b0100;
        repeat (2) tick();
        req = '0;
        waitDone("t7", w, 1'b0, d);
        ptr  = (w + 1) % NREQ;
        seen = '0;
        repeat (5) begin
            tick();
            seen |= gnt;
        end
        checkOutput("t7.noGnt", 32'(seen), 32'd0);

        // Random masks, operands and latencies against the round-robin model.
        for (int t = 0; t < 16; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                aOp[i] = 8'($urandom);
                bOp[i] = 8'($urandom);
            end
            mulLat = $urandom_range(1, 6);
            req    = mask;
            w      = pickModel(mask, ptr);
            waitGnt("rnd", w, d);
            if ($urandom_range(0, 1) == 1) req = '0;
            waitDone("rnd", w, 1'b0, d);
            ptr = (w + 1) % NREQ;
        end
        req = '0;
        tick();

        // Multiplier that never answers.
        aOp[0] = 8'($urandom);
        bOp[0] = 8'($urandom);
        mulLat = 0;
        req    = 4'b0001;
        w      = pickModel(req, ptr);
        waitGnt("t6", w, d);
`ifdef MULT_ARB_TIMEOUT_EN
        waitDone("t6", w, 1'b1, d);
        checkOutput("t6.doneLat", 32'(d), 32'd65);
        req = '0;
        tick();
`else
        repeat (100) tick();
        checkOutput("t6.busy", 32'(busy), 32'd1);
        checkOutput("t6.err", 32'(err), 32'd0);
        checkOutput("t6.done", 32'(done), 32'd0);
        resetDut();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
